board_ram_arbiter: RTL and testbench

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

---
 rtl/board_ram_arbiter_pkg.sv | 22 ++
 rtl/board_ram_arbiter_rr_pick.sv | 35 +++
 rtl/board_ram_arbiter.sv | 110 +++++++++++
 tb/tb_board_ram_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/board_ram_arbiter_pkg.sv
// Shared tetris board constants, requester indices and arbiter state encoding.
package board_ram_arbiter_pkg;

  localparam int BOARD_ADDR_W  = 8;
  localparam int COLOUR_W      = 6;

  localparam int REQ_COLLISION = 0;
  localparam int REQ_ADD       = 1;
  localparam int REQ_DRAW      = 2;
  localparam int REQ_ROWCLR    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot winner plus its index.
module rr_pick
  import board_ram_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] win_idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the ring starting just after last_winner; first active request wins.
  always_comb begin
    winner  = {N_REQ{1'b0}};
    win_idx = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = IDX_W'((32'(last_winner) + 32'(i)) % 32'(N_REQ));
      if (!found_s && req[cand_s]) begin
        winner[cand_s] = 1'b1;
        win_idx        = cand_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/board_ram_arbiter.sv
// Round-robin arbiter sharing the single-port board RAM between game engines.
module board_ram_arbiter
  import board_ram_arbiter_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter logic [7:0] MAX_HOLD = 8'd200
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_REQ-1:0]                 req,
  input  logic [BOARD_ADDR_W*N_REQ-1:0]    addr_i,
  input  logic [COLOUR_W*N_REQ-1:0]        wdata_i,
  input  logic [N_REQ-1:0]                 wren_i,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 rvalid,
  output logic [COLOUR_W-1:0]              rdata,
  output logic                             busy,
  output logic [BOARD_ADDR_W-1:0]          ram_addr,
  output logic [COLOUR_W-1:0]              ram_data,
  output logic                             ram_wren,
  input  logic [COLOUR_W-1:0]              ram_q
);

  localparam int               IDX_W    = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e       state_r;
  logic [7:0]       hold_cnt_r;
  logic [IDX_W-1:0] last_winner_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic [N_REQ-1:0] winner_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [N_REQ-1:0] sel_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner_r),
    .winner      (winner_s),
    .win_idx     (win_idx_s)
  );

  // Arbitration FSM; leaving TURN re-arbitrates at once so the gap is one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      gnt           <= {N_REQ{1'b0}};
      busy          <= 1'b0;
      hold_cnt_r    <= 8'd0;
      last_winner_r <= LAST_RST;
      gnt_idx_r     <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_TURN: begin
          if (|req) begin
            state_r       <= ST_GRANT;
            gnt           <= winner_s;
            busy          <= 1'b1;
            hold_cnt_r    <= 8'd0;
            last_winner_r <= win_idx_s;
            gnt_idx_r     <= win_idx_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!req[gnt_idx_r] || (hold_cnt_r == MAX_HOLD - 8'd1)) begin
            state_r <= ST_TURN;
            gnt     <= {N_REQ{1'b0}};
            busy    <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt     <= {N_REQ{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives one cycle after a granted read, matching the RAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= {N_REQ{1'b0}};
    end else begin
      rvalid <= gnt & req & ~wren_i;
    end
  end

  assign sel_s = (state_r == ST_GRANT) ? gnt : {N_REQ{1'b0}};
  assign rdata = ram_q;

  // One-hot AND-OR mux of the granted requester onto the RAM port.
  always_comb begin
    ram_addr = {BOARD_ADDR_W{1'b0}};
    ram_data = {COLOUR_W{1'b0}};
    ram_wren = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      ram_addr = ram_addr | ({BOARD_ADDR_W{sel_s[k]}} & addr_i[k*BOARD_ADDR_W +: BOARD_ADDR_W]);
      ram_data = ram_data | ({COLOUR_W{sel_s[k]}} & wdata_i[k*COLOUR_W +: COLOUR_W]);
      ram_wren = ram_wren | (sel_s[k] & req[k] & wren_i[k]);
    end
  end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed-vector bench: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_board_ram_arbiter;
  import board_ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] addr_i;
  logic [23:0] wdata_i;
  logic [3:0]  wren_i;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [5:0]  rdata;
  logic        busy;
  logic [7:0]  ram_addr;
  logic [5:0]  ram_data;
  logic        ram_wren;
  logic [5:0]  ram_q;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] rvalid;
    logic       busy;
    logic [7:0] addr;
    logic [5:0] data;
    logic       wren;
    logic [5:0] rdata;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         q_seed   = 3;
  logic [7:0] addr_tab [4];
  logic [5:0] data_tab [4];

  board_ram_arbiter #(
    .N_REQ    (4),
    .MAX_HOLD (8'd4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .wren_i   (wren_i),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s actual=%0h required=%0h", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what that cycle must show.
  task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] w,
                      input logic [3:0] eg, input logic [3:0] erv, input logic ew, input string nm);
    exp_t e;
    reset_n = rn;
    req     = r;
    wren_i  = w;
    ram_q   = q_seed[5:0];
    q_seed  = q_seed + 7;
    e.gnt    = eg;
    e.rvalid = erv;
    e.busy   = |eg;
    e.addr   = 8'h00;
    e.data   = 6'h00;
    e.wren   = ew;
    e.rdata  = ram_q;
    e.name   = nm;
    for (int k = 0; k < 4; k++) begin
      if (eg[k]) begin
        e.addr = addr_tab[k];
        e.data = data_tab[k];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle sample of every output against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.name, "gnt",      32'(gnt),      32'(e.gnt));
        chk(e.name, "rvalid",   32'(rvalid),   32'(e.rvalid));
        chk(e.name, "busy",     32'(busy),     32'(e.busy));
        chk(e.name, "ram_addr", 32'(ram_addr), 32'(e.addr));
        chk(e.name, "ram_data", 32'(ram_data), 32'(e.data));
        chk(e.name, "ram_wren", 32'(ram_wren), 32'(e.wren));
        chk(e.name, "rdata",    32'(rdata),    32'(e.rdata));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] req_now;
    logic [3:0] bitk;
    addr_tab[REQ_COLLISION] = 8'h05;
    addr_tab[REQ_ADD]       = 8'h21;
    addr_tab[REQ_DRAW]      = 8'h37;
    addr_tab[REQ_ROWCLR]    = 8'h10;
    data_tab[REQ_COLLISION] = 6'h0A;
    data_tab[REQ_ADD]       = 6'h15;
    data_tab[REQ_DRAW]      = 6'h2A;
    data_tab[REQ_ROWCLR]    = 6'h3F;
    addr_i  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    wdata_i = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
    reset_n = 1'b0;
    req     = 4'b0000;
    wren_i  = 4'b0000;
    ram_q   = 6'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset holds everything low even with all requests and writes active
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, "rst_a");
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, "rst_b");

    // Single requester 2 reading address 8'h37
    step(1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, "single_c0");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, "single_c1");
    step(1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0, "single_c2");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "single_c3");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "single_c4");

    // Contention after reset: order 0,1,2,3, 3-cycle bursts, one idle cycle between
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "cont_rst");
    req_now = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bitk = 4'b0001 << k;
      step(1'b1, req_now, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("cont%0d_gap", k));
      step(1'b1, req_now, 4'b0000, bitk,    4'b0000, 1'b0, $sformatf("cont%0d_g1", k));
      step(1'b1, req_now, 4'b0000, bitk,    bitk,    1'b0, $sformatf("cont%0d_g2", k));
      req_now = req_now & ~bitk;
      step(1'b1, req_now, 4'b0000, bitk,    bitk,    1'b0, $sformatf("cont%0d_g3", k));
    end
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "cont_end");

    // Write gating: requester 1 granted, requester 3 asserting wren at 8'h10
    step(1'b1, 4'b1010, 4'b1000, 4'b0000, 4'b0000, 1'b0, "wg_c0");
    step(1'b1, 4'b1010, 4'b1010, 4'b0010, 4'b0000, 1'b1, "wg_c1");
    step(1'b1, 4'b1010, 4'b1000, 4'b0010, 4'b0000, 1'b0, "wg_c2");
    step(1'b1, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 1'b0, "wg_c3");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "wg_c4");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "wg_c5");

    // Timeout at MAX_HOLD=4 with requester 1 waiting
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_c0");
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, "to_c1");
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b0, "to_c2");
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b0, "to_c3");
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b0, "to_c4");
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, "to_turn");
    step(1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 1'b0, "to_g1");
    step(1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 1'b0, "to_g1_end");
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, "to_turn2");

    // Early release: requester 0 drops req while asserting wren
    step(1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, "er_g");
    step(1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0, "er_drop");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "er_turn");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "er_idle");

    // Reset mid-burst, then requester 0 wins first
    step(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rm_c0");
    step(1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, "rm_c1");
    step(1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, "rm_c2");
    step(1'b0, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0, "rm_rst");
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rm_rel");
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, "rm_first");
    step(1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, "rm_drop");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rm_turn");

    @(negedge clk);
    #1;
    chk("sb_drain", "pending", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
